// File: rtl/rob_param.sv
`timescale 1ns/1ps
// Parametrised in-order-commit reorder buffer.
// Entries are allocated at the tail and retired from the head once they are
// ready. Register, branch and JALR commits take one cycle. Stores go through a
// two-state memory handshake. A mispredicted branch or a JALR raises a one-cycle
// registered flush, and the edge at the end of that cycle empties the buffer.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | no store in flight; the head entry commits once it is ready
// S_WAIT_MEM | mem_req held for the head store until mem_ack is seen with rdy
module rob_param #(
   parameter int DEPTH  = 16,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              alloc_valid,
   input  logic [1:0]        alloc_kind,
   input  logic [REG_W-1:0]  alloc_rd,
   input  logic [1:0]        alloc_size,
   input  logic [DATA_W-1:0] alloc_pc,
   input  logic              alloc_pred,
   output logic              alloc_ready,
   output logic [PTR_W-1:0]  alloc_tag,
   output logic [PTR_W:0]    count,
   output logic              full,
   output logic              empty,
   input  logic [PTR_W-1:0]  q1_tag,
   input  logic [PTR_W-1:0]  q2_tag,
   output logic [DATA_W-1:0] q1_value,
   output logic [DATA_W-1:0] q2_value,
   output logic              q1_ready,
   output logic              q2_ready,
   input  logic              alu_wb_valid,
   input  logic [PTR_W-1:0]  alu_wb_tag,
   input  logic [DATA_W-1:0] alu_wb_value,
   input  logic [DATA_W-1:0] alu_wb_newpc,
   input  logic              lsb_wb_valid,
   input  logic [PTR_W-1:0]  lsb_wb_tag,
   input  logic [DATA_W-1:0] lsb_wb_value,
   input  logic [DATA_W-1:0] lsb_wb_addr,
   input  logic [DATA_W-1:0] chk_addr,
   output logic              chk_hit,
   output logic              cmt_reg_valid,
   output logic [REG_W-1:0]  cmt_reg_rd,
   output logic [PTR_W-1:0]  cmt_reg_tag,
   output logic [DATA_W-1:0] cmt_reg_value,
   output logic              mem_req,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic [1:0]        mem_size,
   input  logic              mem_ack,
   output logic              bp_valid,
   output logic [DATA_W-1:0] bp_pc,
   output logic              bp_taken,
   output logic              flush,
   output logic [DATA_W-1:0] flush_pc
);

   localparam logic [1:0] K_REG    = 2'd0;
   localparam logic [1:0] K_BRANCH = 2'd1;
   localparam logic [1:0] K_STORE  = 2'd2;
   localparam logic [1:0] K_JALR   = 2'd3;

   typedef enum logic {S_IDLE, S_WAIT_MEM} st_t;

   typedef struct packed {
      logic              valid;
      logic              ready;
      logic              addr_valid;
      logic [1:0]        kind;
      logic [REG_W-1:0]  rd;
      logic [1:0]        size;
      logic              pred;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] value;
      logic [DATA_W-1:0] newpc;
      logic [DATA_W-1:0] addr;
   } entry_t;

   entry_t            ent_q [DEPTH];
   entry_t            ent_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [PTR_W:0]    count_q, count_d;
   st_t               st_q, st_d;

   logic              cmt_reg_valid_q, cmt_reg_valid_d;
   logic [REG_W-1:0]  cmt_reg_rd_q, cmt_reg_rd_d;
   logic [PTR_W-1:0]  cmt_reg_tag_q, cmt_reg_tag_d;
   logic [DATA_W-1:0] cmt_reg_value_q, cmt_reg_value_d;
   logic              mem_req_q, mem_req_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic [1:0]        mem_size_q, mem_size_d;
   logic              bp_valid_q, bp_valid_d;
   logic [DATA_W-1:0] bp_pc_q, bp_pc_d;
   logic              bp_taken_q, bp_taken_d;
   logic              flush_q, flush_d;
   logic [DATA_W-1:0] flush_pc_q, flush_pc_d;

   entry_t            hd;
   logic              do_alloc;
   logic              retire;
   logic              alu_hit;
   logic              lsb_hit;
   logic              unused_chk;

   assign hd          = ent_q[head_q];
   assign full        = (count_q == (PTR_W+1)'(DEPTH));
   assign empty       = (count_q == '0);
   assign count       = count_q;
   assign alloc_tag   = tail_q;
   assign alloc_ready = !full && !flush_q;

   // Only the word address takes part in the collision check.
   assign unused_chk  = ^chk_addr[1:0];

   assign q1_value    = ent_q[q1_tag].value;
   assign q1_ready    = ent_q[q1_tag].ready;
   assign q2_value    = ent_q[q2_tag].value;
   assign q2_ready    = ent_q[q2_tag].ready;

   assign cmt_reg_valid = cmt_reg_valid_q;
   assign cmt_reg_rd    = cmt_reg_rd_q;
   assign cmt_reg_tag   = cmt_reg_tag_q;
   assign cmt_reg_value = cmt_reg_value_q;
   assign mem_req       = mem_req_q;
   assign mem_addr      = mem_addr_q;
   assign mem_data      = mem_data_q;
   assign mem_size      = mem_size_q;
   assign bp_valid      = bp_valid_q;
   assign bp_pc         = bp_pc_q;
   assign bp_taken      = bp_taken_q;
   assign flush         = flush_q;
   assign flush_pc      = flush_pc_q;

   // Word-granular match against every pending store with a known address.
   always_comb begin
      chk_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].valid && ent_q[i].kind == K_STORE && ent_q[i].addr_valid &&
             ent_q[i].addr[DATA_W-1:2] == chk_addr[DATA_W-1:2]) begin
            chk_hit = 1'b1;
         end
      end
   end

   // Next state: allocation, writeback, commit/store FSM and flush.
   always_comb begin
      ent_d           = ent_q;
      head_d          = head_q;
      tail_d          = tail_q;
      count_d         = count_q;
      st_d            = st_q;
      cmt_reg_valid_d = cmt_reg_valid_q;
      cmt_reg_rd_d    = cmt_reg_rd_q;
      cmt_reg_tag_d   = cmt_reg_tag_q;
      cmt_reg_value_d = cmt_reg_value_q;
      mem_req_d       = mem_req_q;
      mem_addr_d      = mem_addr_q;
      mem_data_d      = mem_data_q;
      mem_size_d      = mem_size_q;
      bp_valid_d      = bp_valid_q;
      bp_pc_d         = bp_pc_q;
      bp_taken_d      = bp_taken_q;
      flush_d         = flush_q;
      flush_pc_d      = flush_pc_q;
      do_alloc        = 1'b0;
      retire          = 1'b0;
      alu_hit         = 1'b0;
      lsb_hit         = 1'b0;

      if (rdy) begin
         cmt_reg_valid_d = 1'b0;
         bp_valid_d      = 1'b0;
         flush_d         = 1'b0;

         if (flush_q) begin
            for (int i = 0; i < DEPTH; i++) begin
               ent_d[i].valid      = 1'b0;
               ent_d[i].ready      = 1'b0;
               ent_d[i].addr_valid = 1'b0;
            end
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            st_d      = S_IDLE;
            mem_req_d = 1'b0;
         end else begin
            do_alloc = alloc_valid && alloc_ready;
            alu_hit  = alu_wb_valid && ent_q[alu_wb_tag].valid;
            // ALU has priority when both ports name the same entry.
            lsb_hit  = lsb_wb_valid && ent_q[lsb_wb_tag].valid &&
                       !(alu_wb_valid && alu_wb_tag == lsb_wb_tag);

            if (lsb_hit) begin
               ent_d[lsb_wb_tag].value = lsb_wb_value;
               ent_d[lsb_wb_tag].ready = 1'b1;
               if (ent_q[lsb_wb_tag].kind == K_STORE) begin
                  ent_d[lsb_wb_tag].addr       = lsb_wb_addr;
                  ent_d[lsb_wb_tag].addr_valid = 1'b1;
               end
            end
            if (alu_hit) begin
               ent_d[alu_wb_tag].value = alu_wb_value;
               ent_d[alu_wb_tag].newpc = alu_wb_newpc;
               ent_d[alu_wb_tag].ready = 1'b1;
            end

            if (st_q == S_WAIT_MEM) begin
               if (mem_ack) begin
                  mem_req_d = 1'b0;
                  retire    = 1'b1;
                  st_d      = S_IDLE;
               end
            end else if (hd.valid && hd.ready) begin
               case (hd.kind)
                  K_REG: begin
                     cmt_reg_valid_d = 1'b1;
                     cmt_reg_rd_d    = hd.rd;
                     cmt_reg_tag_d   = head_q;
                     cmt_reg_value_d = hd.value;
                     retire          = 1'b1;
                  end
                  K_BRANCH: begin
                     bp_valid_d = 1'b1;
                     bp_pc_d    = hd.pc;
                     bp_taken_d = hd.value[0];
                     if (hd.value[0] != hd.pred) begin
                        flush_d    = 1'b1;
                        flush_pc_d = hd.value[0] ? hd.newpc : hd.pc + DATA_W'(4);
                     end
                     retire = 1'b1;
                  end
                  K_JALR: begin
                     cmt_reg_valid_d = 1'b1;
                     cmt_reg_rd_d    = hd.rd;
                     cmt_reg_tag_d   = head_q;
                     cmt_reg_value_d = hd.value;
                     flush_d         = 1'b1;
                     flush_pc_d      = hd.newpc;
                     retire          = 1'b1;
                  end
                  default: begin
                     mem_req_d  = 1'b1;
                     mem_addr_d = hd.addr;
                     mem_data_d = hd.value;
                     mem_size_d = hd.size;
                     st_d       = S_WAIT_MEM;
                  end
               endcase
            end

            if (retire) begin
               ent_d[head_q].valid      = 1'b0;
               ent_d[head_q].ready      = 1'b0;
               ent_d[head_q].addr_valid = 1'b0;
               head_d                   = head_q + PTR_W'(1);
            end

            // The tail slot is never the retiring head: alloc needs !full.
            if (do_alloc) begin
               ent_d[tail_q]       = '0;
               ent_d[tail_q].valid = 1'b1;
               ent_d[tail_q].kind  = alloc_kind;
               ent_d[tail_q].rd    = alloc_rd;
               ent_d[tail_q].size  = alloc_size;
               ent_d[tail_q].pc    = alloc_pc;
               ent_d[tail_q].pred  = alloc_pred;
               tail_d              = tail_q + PTR_W'(1);
            end

            count_d = count_q + (PTR_W+1)'(do_alloc) - (PTR_W+1)'(retire);
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         st_q            <= S_IDLE;
         cmt_reg_valid_q <= 1'b0;
         cmt_reg_rd_q    <= '0;
         cmt_reg_tag_q   <= '0;
         cmt_reg_value_q <= '0;
         mem_req_q       <= 1'b0;
         mem_addr_q      <= '0;
         mem_data_q      <= '0;
         mem_size_q      <= '0;
         bp_valid_q      <= 1'b0;
         bp_pc_q         <= '0;
         bp_taken_q      <= 1'b0;
         flush_q         <= 1'b0;
         flush_pc_q      <= '0;
      end else begin
         ent_q           <= ent_d;
         head_q          <= head_d;
         tail_q          <= tail_d;
         count_q         <= count_d;
         st_q            <= st_d;
         cmt_reg_valid_q <= cmt_reg_valid_d;
         cmt_reg_rd_q    <= cmt_reg_rd_d;
         cmt_reg_tag_q   <= cmt_reg_tag_d;
         cmt_reg_value_q <= cmt_reg_value_d;
         mem_req_q       <= mem_req_d;
         mem_addr_q      <= mem_addr_d;
         mem_data_q      <= mem_data_d;
         mem_size_q      <= mem_size_d;
         bp_valid_q      <= bp_valid_d;
         bp_pc_q         <= bp_pc_d;
         bp_taken_q      <= bp_taken_d;
         flush_q         <= flush_d;
         flush_pc_q      <= flush_pc_d;
      end
   end

endmodule
